inst_mem_loadable: RTL and testbench

Parametrised, loadable instruction memory for the MIPS fetch stage. It replaces a hard-wired instruction ROM with a RAM array of configurable width and depth. The array is filled through a valid/ready load port while `Set` is held high. The fetch stage then reads it through a request/valid port with one-cycle latency. Addresses that were never loaded, or that lie outside the array, return a configurable fill word.

---
 rtl/inst_mem_pkg.sv | 16 +
 rtl/inst_mem_loadable_if.sv | 30 +++
 rtl/inst_mem_ram.sv | 24 ++
 rtl/inst_mem_loadable.sv | 110 +++++++++++
 tb/tb_inst_mem_loadable.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package inst_mem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam logic [15:0] FILL_WORD_DEFAULT = 16'h8000;

  // Even parity over a word of up to 64 bits; callers zero-extend.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// Load and fetch port bundle of the loadable instruction memory.
interface inst_mem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              Set;
  logic              LdValid;
  logic [DATA_W-1:0] LdData;
  logic              LdReady;
  logic              FetchReq;
  logic [ADDR_W-1:0] Addr;
  logic              FetchReady;
  logic [DATA_W-1:0] Inst;
  logic              InstValid;
  logic [CNT_W-1:0]  LoadCount;
  logic              ParErr;

  modport master (
    output Set, LdValid, LdData, FetchReq, Addr,
    input  LdReady, FetchReady, Inst, InstValid, LoadCount, ParErr
  );

  modport slave (
    input  Set, LdValid, LdData, FetchReq, Addr,
    output LdReady, FetchReady, Inst, InstValid, LoadCount, ParErr
  );
endinterface

// File: rtl/inst_mem_ram.sv
// Single-port synchronous RAM: write port plus registered, enable-gated read port.
module inst_mem_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Read data only updates on an enabled read, so the output holds between fetches.
  always_ff @(posedge clk) begin
    if (we) mem_reg[addr] <= wdata;
    if (re) rdata_reg <= mem_reg[addr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: RUN/LOAD FSM, load watermark, fill-word and parity muxing.
// Optional parity storage/checking is compiled in with INSTMEM_PARITY_EN.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT)
) (
  input logic clk,
  input logic rst,
  inst_mem_loadable_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
`ifdef INSTMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             inst_valid_reg;
  logic             fill_sel_reg;

  logic             ld_ready;
  logic             fetch_ok;
  logic             load_ok;
  logic [ADDR_W:0]  addr_ext;
  logic [ADDR_W:0]  count_ext;
  logic [IDX_W-1:0] ram_addr;
  logic [MEM_W-1:0] ram_wdata;
  logic [MEM_W-1:0] ram_rdata;

  // The load pointer and the watermark always move together, so one register serves both.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ld_ready   = 1'b0;
    fetch_ok   = 1'b0;
    unique case (state_reg)
      RUN: begin
        fetch_ok = bus.FetchReq && !bus.Set;
        if (bus.Set) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        ld_ready = (count_reg < DEPTH_C);
        if (bus.LdValid && ld_ready) count_next = count_reg + 1'b1;
        if (!bus.Set) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign load_ok   = (state_reg == LOAD) && bus.LdValid && ld_ready && !rst;
  assign addr_ext  = {1'b0, bus.Addr};
  assign count_ext = (ADDR_W + 1)'(count_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      count_reg      <= '0;
      inst_valid_reg <= 1'b0;
      fill_sel_reg   <= 1'b1;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      inst_valid_reg <= fetch_ok;
      if (fetch_ok) fill_sel_reg <= (addr_ext >= DEPTH_A) || (addr_ext >= count_ext);
    end
  end

  // Loads and fetches never overlap in time, so a single shared address port suffices.
  assign ram_addr = (state_reg == LOAD) ? count_reg[IDX_W-1:0] : bus.Addr[IDX_W-1:0];

`ifdef INSTMEM_PARITY_EN
  assign ram_wdata  = {even_parity(64'(bus.LdData)), bus.LdData};
  assign bus.ParErr = inst_valid_reg && !fill_sel_reg &&
                      (ram_rdata[DATA_W] != even_parity(64'(ram_rdata[DATA_W-1:0])));
`else
  assign ram_wdata  = bus.LdData;
  assign bus.ParErr = 1'b0;
`endif

  inst_mem_ram #(
    .WIDTH(MEM_W),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (load_ok),
    .re   (fetch_ok),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign bus.LdReady    = ld_ready;
  assign bus.FetchReady = (state_reg == RUN) && !bus.Set;
  assign bus.Inst       = fill_sel_reg ? FILL_WORD : ram_rdata[DATA_W-1:0];
  assign bus.InstValid  = inst_valid_reg;
  assign bus.LoadCount  = count_reg;
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed plus randomized bench for inst_mem_loadable against an array-based reference model.
module tb_inst_mem_loadable;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] FILL   = 16'h8000;

  logic clk;
  logic rst;

  inst_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  inst_mem_loadable #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILL_WORD(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what has been loaded and what the last response was.
  logic [15:0] m_mem [DEPTH];
  int          m_cnt     = 0;
  bit          m_loading = 0;
  logic [15:0] m_last    = FILL;
  bit          m_valid   = 0;
  bit          m_par     = 0;
  int          m_corrupt = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int a);
    if (a < DEPTH && a < m_cnt) return m_mem[a];
    return FILL;
  endfunction

  // One clock cycle: apply inputs, check handshakes, advance model, check registered outputs.
  task automatic drive(input bit r, input bit s, input bit req, input int addr,
                       input bit ldv, input logic [15:0] ldd);
    bit acc_f, acc_l;
    rst = r; bus.Set = s; bus.FetchReq = req; bus.Addr = 16'(addr);
    bus.LdValid = ldv; bus.LdData = ldd;
    #1;
    if (!r) begin
      chk("fetch_ready", {31'b0, bus.FetchReady}, {31'b0, !m_loading && !s});
      chk("ld_ready", {31'b0, bus.LdReady}, {31'b0, m_loading && (m_cnt < DEPTH)});
    end
    if (r) begin
      m_loading = 0; m_cnt = 0; m_last = FILL; m_valid = 0; m_par = 0;
    end else begin
      acc_f = !m_loading && !s && req;
      acc_l = m_loading && ldv && (m_cnt < DEPTH);
      m_valid = acc_f;
      m_par = acc_f && (addr == m_corrupt) && (addr < m_cnt);
      if (acc_f) begin
        m_last = exp_word(addr);
        $display("fetch addr=%0d expect=%h", addr, m_last);
      end
      if (acc_l) begin
        $display("load  idx=%0d data=%h", m_cnt, ldd);
        m_mem[m_cnt] = ldd;
        m_cnt++;
      end
      if (!m_loading && s) begin
        m_loading = 1; m_cnt = 0;
      end else if (m_loading && !s) begin
        m_loading = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("inst_valid", {31'b0, bus.InstValid}, {31'b0, m_valid});
    chk("inst", {16'b0, bus.Inst}, {16'b0, m_last});
    chk("load_count", 32'(bus.LoadCount), 32'(m_cnt));
    chk("par_err", {31'b0, bus.ParErr}, {31'b0, m_par});
  endtask

  initial begin
    rst = 1'b1; bus.Set = 1'b0; bus.FetchReq = 1'b0; bus.Addr = '0;
    bus.LdValid = 1'b0; bus.LdData = '0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Fetch after reset returns the fill word.
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Load three words, then fetch 0..3 back-to-back.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 16'h1E50);
    drive(0, 1, 0, 0, 1, 16'h1098);
    drive(0, 1, 0, 0, 1, 16'h20E0);
    drive(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) drive(0, 0, 1, a, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Offer six words to a four-deep array, then fetch beyond the end.
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 1, 16'(16'hA000 + i));
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 5, 0, 0);
    drive(0, 0, 1, 3, 0, 0);
    drive(0, 0, 1, 16'hFFFF, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Fetch arriving with Set is dropped; the block enters LOAD.
    drive(0, 1, 1, 2, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Reset aborts a load in progress.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 16'h1111);
    drive(0, 1, 0, 0, 1, 16'h2222);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Randomized load/fetch rounds.
    for (int round = 0; round < 8; round++) begin
      int n;
      n = $urandom_range(0, 7);
      drive(0, 1, $urandom_range(0, 1), 0, 0, 0);
      for (int i = 0; i < n; i++)
        drive(0, 1, $urandom_range(0, 1), 0, $urandom_range(0, 1), 16'($urandom));
      drive(0, 0, 0, 0, $urandom_range(0, 1), 16'($urandom));
      for (int i = 0; i < 10; i++) begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 65535)) : int'($urandom_range(0, 5));
        drive(0, ($urandom_range(0, 9) == 0), $urandom_range(0, 3) != 0, a, 0, 0);
      end
      drive(0, 0, 0, 0, 0, 0);
    end

`ifdef INSTMEM_PARITY_EN
    // A flipped stored bit must be reported with the response.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 16'h3098);
    drive(0, 0, 0, 0, 0, 0);
    dut.u_ram.mem_reg[0][3] = ~dut.u_ram.mem_reg[0][3];
    m_mem[0] = m_mem[0] ^ 16'h0008;
    m_corrupt = 0;
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
